// File: rtl/mem_ctrl_pkg.sv
// Shared types for the main-memory controller: block address/data, request
// kinds, FSM states, port identifiers and the buffered-request record.
package mem_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;

  typedef logic [ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [DATA_W-1:0] block_data_t;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} mem_ctrl_state_t;
  typedef enum logic {PORT_ICACHE = 1'b0, PORT_DCACHE = 1'b1} mem_port_t;

  typedef struct packed {
    req_type_t            typ;
    main_mem_block_addr_t addr;
    block_data_t          data;
  } mem_req_t;

  // Saturating increment for the optional access counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_ctrl_req_buf.sv
// One-entry request buffer. Accepts when empty, holds until the arbiter
// grants it; ready is simply "not full" so it is registered.
module mem_ctrl_req_buf
  import mem_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_aL,
  input  logic     valid_i,
  input  mem_req_t req_i,
  input  logic     clr_i,
  output logic     ready_o,
  output logic     full_o,
  output mem_req_t req_o
);

  logic     full_q;
  mem_req_t req_q;

  // Grant clears; accept only possible while empty, so the two never collide.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (valid_i && !full_q) begin
      full_q <= 1'b1;
      req_q  <= req_i;
    end
  end

  assign ready_o = ~full_q;
  assign full_o  = full_q;
  assign req_o   = req_q;

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller shared by icache (read) and dcache (read/write-through).
// One buffered request per port, strict icache priority, fixed-latency access,
// single-cycle response pulse on the owning port.
// Optional feature: define MEM_CTRL_STATS_EN for saturating access counters.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int N_BLOCKS    = 1024,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 icache_req_valid,
  input  main_mem_block_addr_t icache_req_addr,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_addr,
  input  block_data_t          dcache_req_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          resp_block_data
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [31:0]          stat_icache_reads,
  output logic [31:0]          stat_dcache_reads,
  output logic [31:0]          stat_dcache_writes
`endif
);

  localparam int              IDX_W    = $clog2(N_BLOCKS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  mem_ctrl_state_t   state_q;
  logic [CNT_W-1:0]  cnt_q;
  mem_req_t          cur_q;
  mem_port_t         port_q;
  logic              iresp_q, dresp_q;
  block_data_t       rdata_q;

  mem_req_t          ireq, dreq, ibuf_req, dbuf_req;
  logic              ifull, dfull, gnt_i, gnt_d, commit;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_hi;

  block_data_t mem [N_BLOCKS];

  assign ireq.typ  = READ;
  assign ireq.addr = icache_req_addr;
  assign ireq.data = '0;
  assign dreq.typ  = dcache_req_type;
  assign dreq.addr = dcache_req_addr;
  assign dreq.data = dcache_req_data;

  mem_ctrl_req_buf u_ibuf (
    .clk(clk), .rst_aL(rst_aL), .valid_i(icache_req_valid), .req_i(ireq),
    .clr_i(gnt_i), .ready_o(icache_req_ready), .full_o(ifull), .req_o(ibuf_req)
  );

  mem_ctrl_req_buf u_dbuf (
    .clk(clk), .rst_aL(rst_aL), .valid_i(dcache_req_valid), .req_i(dreq),
    .clr_i(gnt_d), .ready_o(dcache_req_ready), .full_o(dfull), .req_o(dbuf_req)
  );

  // Arbitration looks only at buffered entries; icache always wins.
  assign gnt_i  = (state_q == IDLE) && ifull;
  assign gnt_d  = (state_q == IDLE) && !ifull && dfull;
  assign commit = (state_q == BUSY) && (cnt_q == '0);

  // Block address wraps modulo N_BLOCKS; upper bits intentionally dropped.
  assign idx            = cur_q.addr[IDX_W-1:0];
  assign unused_addr_hi = ^cur_q.addr[ADDR_W-1:IDX_W];

  // Controller FSM: grant, count down the access, pulse the owning port.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      port_q  <= PORT_ICACHE;
      iresp_q <= 1'b0;
      dresp_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      iresp_q <= 1'b0;
      dresp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_i) begin
            cur_q   <= ibuf_req;
            port_q  <= PORT_ICACHE;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end else if (gnt_d) begin
            cur_q   <= dbuf_req;
            port_q  <= PORT_DCACHE;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            // Writes echo their own block so a refill-on-ack is harmless.
            rdata_q <= (cur_q.typ == WRITE) ? cur_q.data : mem[idx];
            iresp_q <= (port_q == PORT_ICACHE);
            dresp_q <= (port_q == PORT_DCACHE);
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Backing store, not reset; writes land only on the final BUSY edge.
  always_ff @(posedge clk) begin
    if (commit && (cur_q.typ == WRITE)) mem[idx] <= cur_q.data;
  end

  assign icache_resp_valid = iresp_q;
  assign dcache_resp_valid = dresp_q;
  assign resp_block_data   = rdata_q;

`ifdef MEM_CTRL_STATS_EN
  logic [31:0] st_ir_q, st_dr_q, st_dw_q;

  // Count each completed access once, on its response cycle.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      st_ir_q <= '0;
      st_dr_q <= '0;
      st_dw_q <= '0;
    end else if (state_q == RESP) begin
      if (port_q == PORT_ICACHE)   st_ir_q <= sat_inc(st_ir_q);
      else if (cur_q.typ == WRITE) st_dw_q <= sat_inc(st_dw_q);
      else                         st_dr_q <= sat_inc(st_dr_q);
    end
  end

  assign stat_icache_reads  = st_ir_q;
  assign stat_dcache_reads  = st_dr_q;
  assign stat_dcache_writes = st_dw_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level timing/memory model checked every
// cycle, plus directed scenarios with literal latencies and data.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int L  = 4;
  localparam int NB = 1024;

  logic                 clk = 1'b0;
  logic                 rst_aL = 1'b1;
  logic                 iv = 1'b0;
  main_mem_block_addr_t ia = '0;
  logic                 ir, irv;
  logic                 dv = 1'b0;
  req_type_t            dt = READ;
  main_mem_block_addr_t da = '0;
  block_data_t          dd = '0;
  logic                 dr, drv;
  block_data_t          rd;
`ifdef MEM_CTRL_STATS_EN
  logic [31:0] s_ir, s_dr, s_dw;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_ctrl #(.N_BLOCKS(NB), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .icache_req_valid(iv), .icache_req_addr(ia), .icache_req_ready(ir),
    .icache_resp_valid(irv),
    .dcache_req_valid(dv), .dcache_req_type(dt), .dcache_req_addr(da),
    .dcache_req_data(dd), .dcache_req_ready(dr), .dcache_resp_valid(drv),
    .resp_block_data(rd)
`ifdef MEM_CTRL_STATS_EN
    , .stat_icache_reads(s_ir), .stat_dcache_reads(s_dr), .stat_dcache_writes(s_dw)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  block_data_t mm [NB];
  bit          mk [NB];
  bit          m_if, m_df;
  mem_req_t    m_ireq, m_dreq, p_req;
  int          m_free, p_cyc;
  bit          p_v;
  mem_port_t   p_port;
  block_data_t m_last;
  bit          m_lk;
  int          n_ir, n_dr, n_dw;

  // Each grant occupies the controller for L+2 cycles; response lands at grant+L+1.
  always @(negedge clk) begin : cmp
    bit ei, ed, acc_i, acc_d;
    int k;
    if (!rst_aL) begin
      m_if = 0; m_df = 0; p_v = 0; m_free = 0;
      m_last = '0; m_lk = 1; n_ir = 0; n_dr = 0; n_dw = 0;
      chk("rst_iready", 64'(ir), 64'd1);
      chk("rst_dready", 64'(dr), 64'd1);
      chk("rst_iresp", 64'(irv), 64'd0);
      chk("rst_dresp", 64'(drv), 64'd0);
      chk("rst_data", rd, 64'd0);
    end else begin
      ei = 0; ed = 0;
      if (p_v && p_cyc == cyc) begin
        k = int'(p_req.addr) % NB;
        if (p_req.typ == WRITE) begin
          mm[k] = p_req.data; mk[k] = 1; m_last = p_req.data; m_lk = 1; n_dw++;
        end else begin
          m_last = mm[k]; m_lk = mk[k];
          if (p_port == PORT_ICACHE) n_ir++; else n_dr++;
        end
        ei = (p_port == PORT_ICACHE);
        ed = !ei;
        p_v = 0;
      end
      chk("iready", 64'(ir), 64'(!m_if));
      chk("dready", 64'(dr), 64'(!m_df));
      chk("iresp", 64'(irv), 64'(ei));
      chk("dresp", 64'(drv), 64'(ed));
      if (m_lk) chk("resp_data", rd, m_last);
      acc_i = iv && !m_if;
      acc_d = dv && !m_df;
      if (cyc >= m_free && (m_if || m_df)) begin
        p_v = 1; p_cyc = cyc + L + 1; m_free = cyc + L + 2;
        if (m_if) begin p_port = PORT_ICACHE; p_req = m_ireq; m_if = 0; end
        else      begin p_port = PORT_DCACHE; p_req = m_dreq; m_df = 0; end
      end
      if (acc_i) begin
        m_if = 1; m_ireq.typ = READ; m_ireq.addr = ia; m_ireq.data = '0;
      end
      if (acc_d) begin
        m_df = 1; m_dreq.typ = dt; m_dreq.addr = da; m_dreq.data = dd;
      end
    end
  end

  // ---------------- directed ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input bit dport, output int t, output block_data_t d);
    t = -1; d = '0;
    for (int k = 0; k < 40 && t < 0; k++) begin
      if (dport ? drv : irv) begin t = cyc; d = rd; end
      else tick();
    end
  endtask

  task automatic dacc(input req_type_t ty, input main_mem_block_addr_t a,
                      input block_data_t wd, output block_data_t d);
    int t0, t;
    dv = 1; dt = ty; da = a; dd = wd; t0 = cyc;
    tick(); dv = 0;
    wait_resp(1'b1, t, d);
    chk("d_lat", 64'(t - t0), 64'd6);
    tick();
  endtask

  task automatic iacc(input main_mem_block_addr_t a, output block_data_t d);
    int t0, t;
    iv = 1; ia = a; t0 = cyc;
    tick(); iv = 0;
    wait_resp(1'b0, t, d);
    chk("i_lat", 64'(t - t0), 64'd6);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t, ti, td, ni, nd, tr;
    block_data_t d, di, dd1, dd2;
    #1 rst_aL = 0;
    repeat (2) tick();
    chk("rst_lit_data", rd, 64'd0);
    chk("rst_lit_ready", 64'({ir, dr}), 64'd3);
    rst_aL = 1;
    tick();

    // write then read back
    dacc(WRITE, 16'h010, 64'hDEADBEEF_CAFEF00D, d);
    chk("wr_ack_data", d, 64'hDEADBEEF_CAFEF00D);
    dacc(READ, 16'h010, '0, d);
    chk("rd_data", d, 64'hDEADBEEF_CAFEF00D);

    // simultaneous requests
    dacc(WRITE, 16'h020, 64'h2222_0000_2222_0000, d);
    dacc(WRITE, 16'h030, 64'h3333_0000_3333_0000, d);
    iv = 1; ia = 16'h020; dv = 1; dt = READ; da = 16'h030; t0 = cyc;
    tick(); iv = 0; dv = 0;
    ti = -1; td = -1; ni = 0; nd = 0; di = '0; dd1 = '0;
    for (int k = 0; k < 20; k++) begin
      if (irv) begin ni++; if (ti < 0) begin ti = cyc; di = rd; end end
      if (drv) begin nd++; if (td < 0) begin td = cyc; dd1 = rd; end end
      tick();
    end
    chk("sim_i_lat", 64'(ti - t0), 64'd6);
    chk("sim_d_lat", 64'(td - t0), 64'd12);
    chk("sim_i_cnt", 64'(ni), 64'd1);
    chk("sim_d_cnt", 64'(nd), 64'd1);
    chk("sim_i_data", di, 64'h2222_0000_2222_0000);
    chk("sim_d_data", dd1, 64'h3333_0000_3333_0000);

    // stall: dcache holds valid while its buffer waits behind icache
    iv = 1; ia = 16'h020; dv = 1; dt = WRITE; da = 16'h050; dd = 64'h5555_AAAA_5555_AAAA;
    t0 = cyc;
    tick(); iv = 0; dt = READ;
    tr = -1;
    for (int k = 0; k < 30 && tr < 0; k++) begin
      if (dr) tr = cyc; else tick();
    end
    chk("stall_ready_rise", 64'(tr - t0), 64'd8);
    tick(); dv = 0;
    nd = 0; td = -1; t = -1; dd1 = '0; dd2 = '0;
    for (int k = 0; k < 22; k++) begin
      if (drv) begin
        nd++;
        if (td < 0) begin td = cyc; dd1 = rd; end else begin t = cyc; dd2 = rd; end
      end
      tick();
    end
    chk("stall_d_pulses", 64'(nd), 64'd2);
    chk("stall_wr_cyc", 64'(td - t0), 64'd12);
    chk("stall_rd_cyc", 64'(t - t0), 64'd18);
    chk("stall_rd_data", dd2, 64'h5555_AAAA_5555_AAAA);
    chk("stall_wr_data", dd1, 64'h5555_AAAA_5555_AAAA);

    // reset during BUSY of a write: the write is lost
    dacc(WRITE, 16'h040, 64'h0000_0000_0000_0401, d);
    dv = 1; dt = WRITE; da = 16'h040; dd = 64'hBAD0_BAD0_BAD0_BAD0;
    tick(); dv = 0;
    tick(); tick();
    rst_aL = 0; #1;
    chk("midrst_data", rd, 64'd0);
    chk("midrst_ready", 64'({ir, dr}), 64'd3);
    chk("midrst_resp", 64'({irv, drv}), 64'd0);
    tick(); tick();
    rst_aL = 1;
    tick();
    dacc(READ, 16'h040, '0, d);
    chk("midrst_old", d, 64'h0000_0000_0000_0401);

    // address wrap
    dacc(WRITE, 16'h400, 64'h0123_4567_89AB_CDEF, d);
    dacc(READ, 16'h000, '0, d);
    chk("wrap_data", d, 64'h0123_4567_89AB_CDEF);

    // three icache reads (stats: 3 ir, 2 dr, 1 dw since reset)
    for (int k = 0; k < 3; k++) begin
      iacc(16'h010, d);
      chk("iread_data", d, 64'hDEADBEEF_CAFEF00D);
    end
    tick();
`ifdef MEM_CTRL_STATS_EN
    chk("stat_ir", 64'(s_ir), 64'd3);
    chk("stat_dr", 64'(s_dr), 64'd2);
    chk("stat_dw", 64'(s_dw), 64'd1);
    chk("stat_ir_model", 64'(s_ir), 64'(n_ir));
`endif
    chk("model_ir", 64'(n_ir), 64'd3);
    chk("model_dw", 64'(n_dw), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
